// File: rtl/adc_avg_filter_mc.sv
// ---------------------------------------------------------------------------
// adc_avg_filter_mc
//
// Multi-channel averaging filter for tagged ADC sample streams. Each channel
// keeps its own accumulator and sample counter. In MODE 1 it also keeps a
// circular history of its last N samples.
//
//   MODE 0 : block average. One result per N samples of a channel (decimating).
//   MODE 1 : sliding boxcar. One result per sample once the window is full.
//
// Results are truncated (acc >> LOG2_N) and registered. A result appears on
// the cycle after the edge that accepts the sample that completes it.
//
// Ports
//   clk        clock
//   reset_n    synchronous reset, active-low; clears everything
//   clear      synchronous flush of channel state and out_valid; beats in_valid
//   in_valid   in_data / in_ch qualify this cycle (no backpressure)
//   in_data    unsigned ADC sample
//   in_ch      channel tag of in_data
//   out_valid  one-cycle strobe per result
//   out_data   averaged sample; holds its value between results
//   out_ch     channel of out_data
//   ch_err     sticky flag: a sample arrived with in_ch >= NUM_CH
// ---------------------------------------------------------------------------
module adc_avg_filter_mc #(
  parameter  int DATA_W = 12,
  parameter  int LOG2_N = 3,
  parameter  int NUM_CH = 2,
  parameter  int MODE   = 0,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              ch_err
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;

  // Per-channel window state. It is only meaningful in MODE 1.
  // In MODE 0 the block cycle is carried entirely by cnt.
  typedef enum logic {
    UNPRIMED = 1'b0,
    PRIMED   = 1'b1
  } prime_t;

  logic [ACC_W-1:0]  acc    [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];  // sample count (MODE 0) / write pointer (MODE 1)
  logic [DATA_W-1:0] hist   [NUM_CH][N];
  prime_t            pstate [NUM_CH];

  logic              ch_ok;
  logic [CH_W-1:0]   idx;
  logic [ACC_W-1:0]  acc_cur;
  logic [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]  cnt_cur;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] oldest;
  logic              last;
  logic              emit;
  logic              accept;
  logic              bad;

  always_comb begin
    // The compare is widened by one bit, so it stays meaningful when NUM_CH
    // is a power of two.
    ch_ok   = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
    // Clamp the index so an out-of-range tag never reads past the arrays.
    idx     = ch_ok ? in_ch : '0;
    acc_cur = acc[idx];
    cnt_cur = cnt[idx];
    oldest  = hist[idx][cnt_cur];
    last    = (cnt_cur == CNT_W'(N - 1));
    cnt_nxt = last ? '0 : cnt_cur + CNT_W'(1);

    if (MODE == 1) begin
      // The intermediate sum may exceed ACC_W bits. The modular subtract
      // still leaves the exact window sum, and that sum always fits.
      acc_nxt = acc_cur + ACC_W'(in_data) - ACC_W'(oldest);
      emit    = last || (pstate[idx] == PRIMED);
    end else begin
      acc_nxt = acc_cur + ACC_W'(in_data);
      emit    = last;
    end

    accept = in_valid && !clear && ch_ok;
    bad    = in_valid && !clear && !ch_ok;
  end

  // Channel state
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc[c]    <= '0;
        cnt[c]    <= '0;
        pstate[c] <= UNPRIMED;
        for (int unsigned j = 0; j < N; j++) begin
          hist[c][j] <= '0;
        end
      end
    end else if (accept) begin
      cnt[idx] <= cnt_nxt;
      if (MODE == 1) begin
        acc[idx]           <= acc_nxt;
        hist[idx][cnt_cur] <= in_data;
        if (last) begin
          pstate[idx] <= PRIMED;
        end
      end else begin
        acc[idx] <= last ? '0 : acc_nxt;
      end
    end
  end

  // Result register and error flag.
  // A clear drops out_valid but keeps out_data, out_ch and ch_err.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ch_err    <= 1'b0;
    end else begin
      out_valid <= accept && emit;
      if (accept && emit) begin
        out_data <= DATA_W'(acc_nxt >> LOG2_N);
        out_ch   <= in_ch;
      end
      if (bad) begin
        ch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_avg_filter_mc.sv
// ---------------------------------------------------------------------------
// tb_adc_avg_filter_mc
//
// Three instances of the filter share one input stream:
//   dut0 : MODE 0, N=8   dut1 : MODE 1, N=4   dut2 : MODE 1, N=1 (pass-through)
// All three use NUM_CH=3, so a tag of 3 is out of range.
//
// The reference model keeps a plain list of samples per channel. A block
// average completes when the list reaches N samples. A boxcar window keeps
// the most recent N samples.
// Expected results go into per-instance queues. A negedge monitor drains
// those queues against whatever the instances present.
// ---------------------------------------------------------------------------
module tb_adc_avg_filter_mc;

  localparam int DW  = 12;
  localparam int NCH = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n  = 1'b0;
  logic        clear    = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data  = '0;
  logic [1:0]  in_ch    = '0;

  logic        ov [3];
  logic [11:0] od [3];
  logic [1:0]  oc [3];
  logic        ce [3];

  adc_avg_filter_mc #(.DATA_W(DW), .LOG2_N(3), .NUM_CH(NCH), .MODE(0)) u_blk (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ch(in_ch), .out_valid(ov[0]), .out_data(od[0]),
    .out_ch(oc[0]), .ch_err(ce[0]));

  adc_avg_filter_mc #(.DATA_W(DW), .LOG2_N(2), .NUM_CH(NCH), .MODE(1)) u_box (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ch(in_ch), .out_valid(ov[1]), .out_data(od[1]),
    .out_ch(oc[1]), .ch_err(ce[1]));

  adc_avg_filter_mc #(.DATA_W(DW), .LOG2_N(0), .NUM_CH(NCH), .MODE(1)) u_pass (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ch(in_ch), .out_valid(ov[2]), .out_data(od[2]),
    .out_ch(oc[2]), .ch_err(ce[2]));

  int mode_d [3] = '{0, 1, 1};
  int lg_d   [3] = '{3, 2, 0};

  typedef struct {
    int ch;
    int data;
    int cyc;
  } exp_t;

  exp_t        expq [3][$];
  int unsigned win  [3][3][$];
  int          last_m [3];
  int          err_m;
  int          cyc_cnt  = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          started  = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc_cnt, act, req);
    end
  endtask

  // The reference model for the sample that will be presented at the next posedge.
  task automatic model(input logic rn, input logic clr, input logic v, input int d, input int c);
    int unsigned s;
    int          n;
    exp_t        e;
    if (!rn) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) win[i][k].delete();
        last_m[i] = 0;
      end
      err_m = 0;
    end else if (clr) begin
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 3; k++) win[i][k].delete();
    end else if (v) begin
      if (c >= NCH) begin
        err_m = 1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          n = 1 << lg_d[i];
          win[i][c].push_back(d);
          if (mode_d[i] == 1 && win[i][c].size() > n) void'(win[i][c].pop_front());
          if (win[i][c].size() == n) begin
            s = 0;
            foreach (win[i][c][k]) s += win[i][c][k];
            e.ch   = c;
            e.data = int'(s >> lg_d[i]);
            e.cyc  = cyc_cnt + 1;
            expq[i].push_back(e);
            if (mode_d[i] == 0) win[i][c].delete();
          end
        end
      end
    end
  endtask

  // Inputs change just after the negedge. The monitor has already sampled by then.
  task automatic step(input logic rn, input logic clr, input logic v, input int d, input int c);
    @(negedge clk);
    #1;
    reset_n  = rn;
    clear    = clr;
    in_valid = v;
    in_data  = d[11:0];
    in_ch    = c[1:0];
    model(rn, clr, v, d, c);
  endtask

  task automatic mon(input int i);
    exp_t e;
    check($sformatf("ch_err_dut%0d", i), int'(ce[i]), err_m);
    if (ov[i]) begin
      if (expq[i].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_dut%0d at cycle %0d: got out_valid=1 ch=%0d data=%0d, required no output",
                 i, cyc_cnt, oc[i], od[i]);
      end else begin
        e = expq[i].pop_front();
        check($sformatf("out_data_dut%0d", i), int'(od[i]), e.data);
        check($sformatf("out_ch_dut%0d", i), int'(oc[i]), e.ch);
        check($sformatf("latency_dut%0d", i), cyc_cnt, e.cyc);
        last_m[i] = e.data;
      end
    end else begin
      check($sformatf("hold_data_dut%0d", i), int'(od[i]), last_m[i]);
      if (expq[i].size() > 0 && expq[i][0].cyc <= cyc_cnt) begin
        e = expq[i].pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_out_dut%0d at cycle %0d: got out_valid=0, required ch=%0d data=%0d",
                 i, cyc_cnt, e.ch, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) mon(i);
    end
  end

  task automatic reset_and_check();
    step(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid_dut%0d", i), int'(ov[i]), 0);
      check($sformatf("rst_data_dut%0d", i), int'(od[i]), 0);
      check($sformatf("rst_ch_dut%0d", i), int'(oc[i]), 0);
      check($sformatf("rst_err_dut%0d", i), int'(ce[i]), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    int r;
    int c;
    int d;
    model(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    started = 1'b1;
    reset_and_check();

    // Ramp 1..8 on channel 0.
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 1'b1, k, 0);
    idle(3);
    reset_and_check();

    // Interleaved channels, 100 / 4000.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b1, (k % 2 == 0) ? 100 : 4000, k % 2);
    idle(3);
    reset_and_check();

    // Boxcar priming: 4,8,12,16,20.
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 1'b1, 4 * k, 0);
    idle(3);

    // Full scale and zero.
    reset_and_check();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b1, 4095, 1);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b1, 0, 1);
    idle(3);

    // Reset mid-block, then clear mid-block with a sample in the clear cycle.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 700 + k, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b1, 16, 0);
    idle(2);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 3000 + k, 0);
    step(1'b1, 1'b1, 1'b1, 2222, 0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b1, 16, 0);
    idle(3);

    // Out-of-range tag among valid samples. The flag is sticky until reset.
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0, 1'b1, 50 + k, 2);
      if (k % 3 == 0) step(1'b1, 1'b0, 1'b1, 4095, 3);
    end
    step(1'b1, 1'b1, 1'b0, 0, 0);
    idle(4);
    reset_and_check();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 3);
      c = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
      d = (r == 0) ? 4095 : (r == 1) ? 0 : $urandom_range(0, 4095);
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0), d, c);
    end
    idle(4);

    for (int i = 0; i < 3; i++) check($sformatf("drain_dut%0d", i), expq[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation time limit, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule
